// File: rtl/udma_scif_tx_ctrl.sv
// -----------------------------------------------------------------------------
// udma_scif_tx_ctrl
//
// Purpose:
//    Transmit controller for a smart-card style serial interface. It takes one
//    byte at a time from a byte source and hands it to a serializer. After each
//    frame it waits a programmable guard time. If the line monitor reports a
//    NACK and NACK handling is enabled, the same byte is retransmitted up to a
//    programmable retry limit. When that limit is exhausted the controller
//    parks in an error state until software clears it.
//
// Ports:
//    clk_i, rst_i          clock, synchronous active-high reset
//    cfg_en_i             block enable (0 forces IDLE and clears all progress)
//    cfg_div_i            bit period = cfg_div_i + 1 clocks
//    cfg_guard_i          guard time after each frame, in bit periods
//    cfg_nack_en_i        enable NACK-driven retransmission
//    cfg_retry_i          maximum retransmissions per byte
//    in_data_i/valid_i    byte source, ready/valid handshake (in_ready_o)
//    ser_data_o/valid_o   byte to serializer, ready/valid handshake (ser_ready_i)
//    ser_busy_i           serializer frame in progress
//    nack_i               line-monitor NACK detect pulse
//    err_o, err_clr_i     retry limit exhausted / clear error
//    tx_done_o            one-cycle pulse when a byte completes without error
//    retry_cnt_o          retransmissions made for the current byte
//    busy_o               controller is not idle
// -----------------------------------------------------------------------------
module udma_scif_tx_ctrl #(
   parameter int unsigned GUARD_W = 8,
   parameter int unsigned RETRY_W = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cfg_en_i,
   input  logic [15:0]        cfg_div_i,
   input  logic [GUARD_W-1:0] cfg_guard_i,
   input  logic               cfg_nack_en_i,
   input  logic [RETRY_W-1:0] cfg_retry_i,
   input  logic [7:0]         in_data_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   output logic [7:0]         ser_data_o,
   output logic               ser_valid_o,
   input  logic               ser_ready_i,
   input  logic               ser_busy_i,
   input  logic               nack_i,
   output logic               err_o,
   input  logic               err_clr_i,
   output logic               tx_done_o,
   output logic [RETRY_W-1:0] retry_cnt_o,
   output logic               busy_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GUARD     = 3'd4,
      S_ERROR     = 3'd5
   } state_e;

   localparam logic [GUARD_W-1:0] GUARD_ONE = GUARD_W'(1);
   localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

   state_e             state_q, state_d;
   logic [7:0]         hold_q, hold_d;
   logic [15:0]        bit_cnt_q, bit_cnt_d;
   logic [GUARD_W-1:0] per_cnt_q, per_cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               nack_q, nack_d;
   logic               done_q, done_d;

   logic               accept_s;
   logic               nack_seen_s;
   logic               bit_wrap_s;
   logic               guard_zero_s;
   logic               guard_last_s;
   logic               exit_ok_s;
   logic               exit_err_s;
   logic               exit_retry_s;
   state_e             exit_state_s;
   logic [RETRY_W-1:0] retry_inc_s;

   // Outputs other than tx_done_o are pure decodes of the registered state,
   // gated only by enable/reset on the source side so nothing is accepted then.
   assign in_ready_o  = (state_q == S_IDLE) & cfg_en_i & ~rst_i;
   assign ser_valid_o = (state_q == S_LOAD);
   assign ser_data_o  = hold_q;
   assign err_o       = (state_q == S_ERROR);
   assign busy_o      = (state_q != S_IDLE);
   assign tx_done_o   = done_q;
   assign retry_cnt_o = retry_q;

   assign accept_s = in_valid_i & in_ready_o;

   // A NACK arriving on the very cycle of the exit decision still counts.
   assign nack_seen_s = nack_q | nack_i;

   // ">=" keeps the bit counter from running away if the divider is lowered live.
   assign bit_wrap_s   = (bit_cnt_q >= cfg_div_i);
   assign guard_zero_s = (cfg_guard_i == '0);
   assign guard_last_s = bit_wrap_s &
                         (guard_zero_s | (per_cnt_q == (cfg_guard_i - GUARD_ONE)));

   // End-of-frame decision shared by WAIT_DONE (zero guard) and GUARD.
   assign exit_ok_s    = ~nack_seen_s | ~cfg_nack_en_i;
   assign exit_err_s   = ~exit_ok_s & (retry_q == cfg_retry_i);
   assign exit_retry_s = ~exit_ok_s & ~exit_err_s;
   assign exit_state_s = exit_ok_s  ? S_IDLE  :
                         exit_err_s ? S_ERROR : S_LOAD;
   assign retry_inc_s  = (retry_q == RETRY_MAX) ? retry_q : (retry_q + RETRY_ONE);

   // Next-state and datapath update for the transmit sequence.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      bit_cnt_d = bit_cnt_q;
      per_cnt_d = per_cnt_q;
      retry_d   = retry_q;
      nack_d    = nack_q;
      done_d    = 1'b0;

      if (!cfg_en_i) begin
         // Disable abandons everything; the held byte is simply left stale.
         state_d   = S_IDLE;
         bit_cnt_d = 16'd0;
         per_cnt_d = '0;
         retry_d   = '0;
         nack_d    = 1'b0;
         done_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  hold_d    = in_data_i;
                  retry_d   = '0;
                  nack_d    = 1'b0;
                  bit_cnt_d = 16'd0;
                  per_cnt_d = '0;
                  state_d   = S_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_LOAD: begin
               if (ser_ready_i) begin
                  state_d = S_WAIT_BUSY;
               end else begin
                  state_d = S_LOAD;
               end
            end
            S_WAIT_BUSY: begin
               if (ser_busy_i) begin
                  state_d = S_WAIT_DONE;
               end else begin
                  state_d = S_WAIT_BUSY;
               end
            end
            S_WAIT_DONE: begin
               nack_d = nack_seen_s;
               if (!ser_busy_i) begin
                  bit_cnt_d = 16'd0;
                  per_cnt_d = '0;
                  if (guard_zero_s) begin
                     state_d = exit_state_s;
                     done_d  = exit_ok_s;
                     retry_d = exit_retry_s ? retry_inc_s : retry_q;
                     nack_d  = exit_retry_s ? 1'b0 : nack_seen_s;
                  end else begin
                     state_d = S_GUARD;
                  end
               end else begin
                  state_d = S_WAIT_DONE;
               end
            end
            S_GUARD: begin
               nack_d = nack_seen_s;
               if (bit_wrap_s) begin
                  bit_cnt_d = 16'd0;
                  if (guard_last_s) begin
                     per_cnt_d = '0;
                     state_d   = exit_state_s;
                     done_d    = exit_ok_s;
                     retry_d   = exit_retry_s ? retry_inc_s : retry_q;
                     nack_d    = exit_retry_s ? 1'b0 : nack_seen_s;
                  end else begin
                     per_cnt_d = per_cnt_q + GUARD_ONE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 16'd1;
               end
            end
            S_ERROR: begin
               if (err_clr_i) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ERROR;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         hold_q    <= 8'h00;
         bit_cnt_q <= 16'd0;
         per_cnt_q <= '0;
         retry_q   <= '0;
         nack_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         bit_cnt_q <= bit_cnt_d;
         per_cnt_q <= per_cnt_d;
         retry_q   <= retry_d;
         nack_q    <= nack_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_udma_scif_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_udma_scif_tx_ctrl
//
// Directed bench for udma_scif_tx_ctrl. Stimulus pushes the expected serializer
// bytes and tx_done retry counts into queues; an independent negedge monitor
// pops and compares them whenever the DUT presents a byte or a done pulse.
// -----------------------------------------------------------------------------
module tb_udma_scif_tx_ctrl;

   localparam int GUARD_W = 8;
   localparam int RETRY_W = 3;

   logic               clk_i;
   logic               rst_i;
   logic               cfg_en_i;
   logic [15:0]        cfg_div_i;
   logic [GUARD_W-1:0] cfg_guard_i;
   logic               cfg_nack_en_i;
   logic [RETRY_W-1:0] cfg_retry_i;
   logic [7:0]         in_data_i;
   logic               in_valid_i;
   logic               in_ready_o;
   logic [7:0]         ser_data_o;
   logic               ser_valid_o;
   logic               ser_ready_i;
   logic               ser_busy_i;
   logic               nack_i;
   logic               err_o;
   logic               err_clr_i;
   logic               tx_done_o;
   logic [RETRY_W-1:0] retry_cnt_o;
   logic               busy_o;

   int checks = 0;
   int errors = 0;

   logic [7:0]         ser_exp_q[$];
   logic [RETRY_W-1:0] done_exp_q[$];

   udma_scif_tx_ctrl #(
      .GUARD_W(GUARD_W),
      .RETRY_W(RETRY_W)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cfg_en_i     (cfg_en_i),
      .cfg_div_i    (cfg_div_i),
      .cfg_guard_i  (cfg_guard_i),
      .cfg_nack_en_i(cfg_nack_en_i),
      .cfg_retry_i  (cfg_retry_i),
      .in_data_i    (in_data_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .ser_data_o   (ser_data_o),
      .ser_valid_o  (ser_valid_o),
      .ser_ready_i  (ser_ready_i),
      .ser_busy_i   (ser_busy_i),
      .nack_i       (nack_i),
      .err_o        (err_o),
      .err_clr_i    (err_clr_i),
      .tx_done_o    (tx_done_o),
      .retry_cnt_o  (retry_cnt_o),
      .busy_o       (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge away from DUT updates.
   always @(negedge clk_i) begin
      if (ser_valid_o === 1'b1 && ser_ready_i === 1'b1) begin
         if (ser_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ser_unexpected: got byte %02h, required no transfer", ser_data_o);
         end else begin
            check("ser_data", 32'(ser_data_o), 32'(ser_exp_q.pop_front()));
         end
      end
      if (tx_done_o !== 1'b0) begin
         if (done_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got tx_done_o=%b, required 0", tx_done_o);
         end else begin
            check("done_retry_cnt", 32'(retry_cnt_o), 32'(done_exp_q.pop_front()));
            check("done_err", 32'(err_o), 32'd0);
         end
      end
   end

   // Offer one byte, wait (bounded) for acceptance, then check LOAD latency.
   task automatic push(input logic [7:0] b);
      int n;
      in_data_i  = b;
      in_valid_i = 1'b1;
      n = 0;
      while (in_ready_o !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("in_ready_wait", 32'(in_ready_o), 32'd1);
      tick();
      in_valid_i = 1'b0;
      check("accept_to_valid", 32'(ser_valid_o), 32'd1);
      check("load_data", 32'(ser_data_o), 32'(b));
   endtask

   // Play the serializer for one frame; lat = ticks from busy fall to outcome.
   task automatic serve(input bit nack, output int lat);
      ser_ready_i = 1'b1;
      tick();
      ser_ready_i = 1'b0;
      ser_busy_i  = 1'b1;
      tick();
      if (nack) begin
         nack_i = 1'b1;
         tick();
         nack_i = 1'b0;
      end
      tick();
      ser_busy_i = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!(tx_done_o === 1'b1 || ser_valid_o === 1'b1 || err_o === 1'b1) && lat < 400);
      if (lat >= 400) check("frame_outcome_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_i         = 1'b1;
      cfg_en_i      = 1'b1;
      cfg_div_i     = 16'd3;
      cfg_guard_i   = 8'd0;
      cfg_nack_en_i = 1'b1;
      cfg_retry_i   = 3'd3;
      in_data_i     = 8'h00;
      in_valid_i    = 1'b0;
      ser_ready_i   = 1'b0;
      ser_busy_i    = 1'b0;
      nack_i        = 1'b0;
      err_clr_i     = 1'b0;
      tick();
      tick();
      // Reset values, with enable already high.
      check("rst_in_ready", 32'(in_ready_o), 32'd0);
      check("rst_ser_valid", 32'(ser_valid_o), 32'd0);
      check("rst_ser_data", 32'(ser_data_o), 32'h00);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_tx_done", 32'(tx_done_o), 32'd0);
      check("rst_retry", 32'(retry_cnt_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      rst_i = 1'b0;
      tick();

      // Zero guard: done pulses on the cycle the falling busy is sampled.
      ser_exp_q.push_back(8'hA5);
      done_exp_q.push_back(3'd0);
      push(8'hA5);
      serve(1'b0, lat);
      check("a_done_lat", 32'(lat), 32'd1);
      check("a_tx_done", 32'(tx_done_o), 32'd1);
      check("a_in_ready", 32'(in_ready_o), 32'd1);
      tick();
      check("a_done_one_cycle", 32'(tx_done_o), 32'd0);

      // div=9, guard=2: 20 clocks spent in GUARD after the busy fall.
      cfg_div_i   = 16'd9;
      cfg_guard_i = 8'd2;
      ser_exp_q.push_back(8'h11);
      done_exp_q.push_back(3'd0);
      push(8'h11);
      serve(1'b0, lat);
      check("b_guard_lat", 32'(lat), 32'd21);
      ser_exp_q.push_back(8'h22);
      done_exp_q.push_back(3'd0);
      push(8'h22);
      serve(1'b0, lat);
      check("b_guard_lat2", 32'(lat), 32'd21);

      // One NACK with retry=3: byte re-presented once, then success.
      cfg_div_i   = 16'd3;
      cfg_guard_i = 8'd1;
      cfg_retry_i = 3'd3;
      ser_exp_q.push_back(8'h3C);
      ser_exp_q.push_back(8'h3C);
      done_exp_q.push_back(3'd1);
      push(8'h3C);
      serve(1'b1, lat);
      check("c_guard_lat", 32'(lat), 32'd5);
      check("c_retry_valid", 32'(ser_valid_o), 32'd1);
      check("c_retry_data", 32'(ser_data_o), 32'h3C);
      check("c_retry_cnt", 32'(retry_cnt_o), 32'd1);
      serve(1'b0, lat);
      check("c_tx_done", 32'(tx_done_o), 32'd1);
      check("c_err", 32'(err_o), 32'd0);

      // NACK every attempt with retry=2: three presentations then ERROR.
      cfg_guard_i = 8'd0;
      cfg_retry_i = 3'd2;
      for (int i = 0; i < 3; i++) ser_exp_q.push_back(8'h5A);
      push(8'h5A);
      for (int i = 0; i < 3; i++) serve(1'b1, lat);
      check("d_err", 32'(err_o), 32'd1);
      check("d_in_ready", 32'(in_ready_o), 32'd0);
      check("d_ser_valid", 32'(ser_valid_o), 32'd0);
      check("d_retry_cnt", 32'(retry_cnt_o), 32'd2);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      check("d_err_clr", 32'(err_o), 32'd0);
      check("d_busy_clr", 32'(busy_o), 32'd0);
      check("d_in_ready_clr", 32'(in_ready_o), 32'd1);

      // retry=0: the first NACK goes straight to ERROR.
      cfg_retry_i = 3'd0;
      ser_exp_q.push_back(8'h42);
      push(8'h42);
      serve(1'b1, lat);
      check("g_err", 32'(err_o), 32'd1);
      check("g_retry_cnt", 32'(retry_cnt_o), 32'd0);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      check("g_err_clr", 32'(err_o), 32'd0);

      // Enable dropped in WAIT_DONE: IDLE next cycle, no done pulse.
      cfg_retry_i = 3'd3;
      ser_exp_q.push_back(8'h77);
      push(8'h77);
      ser_ready_i = 1'b1;
      tick();
      ser_ready_i = 1'b0;
      ser_busy_i  = 1'b1;
      tick();
      nack_i = 1'b1;
      tick();
      nack_i = 1'b0;
      check("e_busy_wait_done", 32'(busy_o), 32'd1);
      cfg_en_i = 1'b0;
      tick();
      check("e_dis_busy", 32'(busy_o), 32'd0);
      check("e_dis_in_ready", 32'(in_ready_o), 32'd0);
      check("e_dis_retry", 32'(retry_cnt_o), 32'd0);
      ser_busy_i = 1'b0;
      cfg_en_i   = 1'b1;
      tick();

      // Reset pulsed in GUARD: byte abandoned, no done or error.
      cfg_guard_i = 8'd4;
      ser_exp_q.push_back(8'h78);
      push(8'h78);
      ser_ready_i = 1'b1;
      tick();
      ser_ready_i = 1'b0;
      ser_busy_i  = 1'b1;
      tick();
      nack_i = 1'b1;
      tick();
      nack_i     = 1'b0;
      ser_busy_i = 1'b0;
      tick();
      tick();
      tick();
      check("e_busy_guard", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      tick();
      check("e_rst_busy", 32'(busy_o), 32'd0);
      check("e_rst_in_ready", 32'(in_ready_o), 32'd0);
      check("e_rst_data", 32'(ser_data_o), 32'h00);
      check("e_rst_err", 32'(err_o), 32'd0);
      check("e_rst_retry", 32'(retry_cnt_o), 32'd0);
      rst_i = 1'b0;
      tick();
      tick();

      // Clean counters after reset: exact guard timing on the next byte.
      cfg_guard_i = 8'd1;
      ser_exp_q.push_back(8'h79);
      done_exp_q.push_back(3'd0);
      push(8'h79);
      serve(1'b0, lat);
      check("e_post_lat", 32'(lat), 32'd5);

      // NACK handling disabled: NACK ignored, done with no retry.
      cfg_nack_en_i = 1'b0;
      ser_exp_q.push_back(8'h99);
      done_exp_q.push_back(3'd0);
      push(8'h99);
      serve(1'b1, lat);
      check("f_tx_done", 32'(tx_done_o), 32'd1);
      check("f_retry_cnt", 32'(retry_cnt_o), 32'd0);
      check("f_ser_valid", 32'(ser_valid_o), 32'd0);
      tick();
      tick();

      check("ser_queue_empty", 32'(ser_exp_q.size()), 32'd0);
      check("done_queue_empty", 32'(done_exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
